// File: rtl/invaders_pkg.sv
// Shared constants, opcodes and state encoding for the interrupt scheduler.
package invaders_pkg;

    localparam logic [7:0] RST1_OPCODE = 8'hCF;
    localparam logic [7:0] RST2_OPCODE = 8'hD7;
    localparam int HALF_FRAME_US_DEFAULT = 8333;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } sched_state_e;

    function automatic logic [7:0] rst_opcode(input logic end_of_frame);
        return end_of_frame ? RST2_OPCODE : RST1_OPCODE;
    endfunction

endpackage

// File: rtl/half_frame_counter.sv
// Microsecond tick counter; flags a deadline on the tick that completes a half frame.
module half_frame_counter
    import invaders_pkg::*;
#(
    parameter int HALF_FRAME_US = HALF_FRAME_US_DEFAULT
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_tick_1us,
    output logic o_deadline
);

    localparam logic [15:0] LAST = 16'(HALF_FRAME_US - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        deadline;

    always_comb begin
        cnt_d    = cnt_q;
        deadline = 1'b0;
        if (i_tick_1us) begin
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                deadline = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_deadline = deadline;

endmodule

// File: rtl/interrupt_scheduler.sv
// Half-frame RST1/RST2 interrupt scheduler for the 8080 core.
// Define INT_MISS_COUNT_EN to build the saturating missed-request counter.
module interrupt_scheduler
    import invaders_pkg::*;
#(
    parameter int HALF_FRAME_US = HALF_FRAME_US_DEFAULT
) (
    input  logic       i_clk_25MHz,
    input  logic       i_reset,
    input  logic       i_tick_1us,
    input  logic       i_int_ack,
    output logic       o_int_req,
    output logic [7:0] o_int_vector,
    output logic       o_frame_strobe,
    output logic [7:0] o_miss_count
);

    logic deadline;

    half_frame_counter #(
        .HALF_FRAME_US(HALF_FRAME_US)
    ) u_counter (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset    (i_reset),
        .i_tick_1us (i_tick_1us),
        .o_deadline (deadline)
    );

    sched_state_e state_q;
    sched_state_e state_d;
    logic [7:0]   vector_q;
    logic [7:0]   vector_d;
    logic         end_next_q;
    logic         end_next_d;
    logic         strobe_q;
    logic         strobe_d;

    always_comb begin
        state_d    = state_q;
        vector_d   = vector_q;
        end_next_d = end_next_q;
        strobe_d   = 1'b0;
        // A deadline wins over an acknowledge in either state
        if (deadline) begin
            state_d    = ST_PENDING;
            vector_d   = rst_opcode(end_next_q);
            end_next_d = ~end_next_q;
            strobe_d   = end_next_q;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_PENDING: begin
                    if (i_int_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            vector_q   <= 8'h00;
            end_next_q <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vector_q   <= vector_d;
            end_next_q <= end_next_d;
            strobe_q   <= strobe_d;
        end
    end

    assign o_int_req      = (state_q == ST_PENDING);
    assign o_int_vector   = vector_q;
    assign o_frame_strobe = strobe_q;

`ifdef INT_MISS_COUNT_EN
    logic       miss_event;
    logic [7:0] miss_q;
    logic [7:0] miss_d;

    assign miss_event = deadline && (state_q == ST_PENDING) && !i_int_ack;

    always_comb begin
        miss_d = miss_q;
        if (miss_event && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset) begin
            miss_q <= 8'h00;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign o_miss_count = miss_q;
`else
    assign o_miss_count = 8'h00;
`endif

endmodule

// File: doc/interrupt_scheduler.md
INTERRUPT_SCHEDULER -- requirements
Module: interrupt_scheduler

Interface
REQ-001 Parameter HALF_FRAME_US, default 8333: number of i_tick_1us pulses between consecutive interrupt deadlines; legal range 2..65535.
REQ-002 i_clk_25MHz  input  1  system clock; all logic on rising edge.
REQ-003 i_reset  input  1  synchronous, active-low reset.
REQ-004 i_tick_1us  input  1  one-cycle pulse from the upstream microsecond timer; each high cycle counts as one tick.
REQ-005 i_int_ack  input  1  CPU interrupt acknowledge; meaningful only while o_int_req is high.
REQ-006 o_int_req  output  1  interrupt request to the 8080 core; level, held until acknowledged.
REQ-007 o_int_vector  output  8  RST opcode to jam on the data bus while o_int_req is high.
REQ-008 o_frame_strobe  output  1  one-cycle pulse at each end-of-frame deadline.
REQ-009 o_miss_count  output  8  saturating count of overwritten (unacknowledged) requests.

Function
REQ-010 The block SHALL hold a 16-bit tick counter that increments on each cycle with i_tick_1us high.
REQ-011 A deadline SHALL occur on a cycle where i_tick_1us is high and the counter equals HALF_FRAME_US-1; the counter then wraps to 0.
REQ-012 Deadlines SHALL alternate mid-frame (RST1, 0xCF) and end-of-frame (RST2, 0xD7); the first deadline after reset is mid-frame.
REQ-013 State machine: IDLE (o_int_req=0) and PENDING (o_int_req=1); a deadline moves to PENDING one cycle later.
REQ-014 o_int_vector SHALL update on the same edge o_int_req rises and remain stable throughout PENDING.
REQ-015 In PENDING, i_int_ack high with no deadline SHALL return to IDLE on the next edge; o_int_vector keeps its last value.
REQ-016 i_int_ack while IDLE SHALL be ignored.
REQ-017 A deadline in PENDING without i_int_ack SHALL stay in PENDING, load the new vector, and count one miss.
REQ-018 A deadline coinciding with i_int_ack SHALL stay in PENDING with the new vector; no miss is counted.
REQ-019 o_frame_strobe SHALL pulse high one cycle after each end-of-frame deadline, independent of handshake state.
REQ-020 Ticks SHALL keep counting in both states; interrupt timing never drifts due to late acknowledgement.

Reset
REQ-021 While i_reset is low: counter=0, state IDLE, o_int_req=0, o_int_vector=0x00, o_frame_strobe=0, o_miss_count=0, next vector=RST1.
REQ-022 Reset asserted in PENDING SHALL drop the request with no acknowledge required.

Configuration
REQ-023 Macro INT_MISS_COUNT_EN: when defined, o_miss_count counts per REQ-017 and saturates at 255.
REQ-024 Without INT_MISS_COUNT_EN, o_miss_count SHALL be constant 0 and no miss counter register is built; all other behaviour is identical.

Structure
REQ-025 Shared package invaders_pkg SHALL hold RST1_OPCODE=8'hCF, RST2_OPCODE=8'hD7, HALF_FRAME_US_DEFAULT=8333 and the IDLE/PENDING state encoding.
REQ-026 The tick counter and deadline compare SHALL be one sub-module, half_frame_counter; the top level holds the FSM, vector select, strobe and miss logic.

Verification (HALF_FRAME_US=4)
REQ-027 Reset release, 4 ticks -> o_int_req=1 and o_int_vector=0xCF on the cycle after the 4th tick; o_frame_strobe stays 0.
REQ-028 Ack, then 4 more ticks -> o_int_req drops next cycle, then rises with 0xD7; o_frame_strobe high exactly one cycle.
REQ-029 No ack across 2 deadlines -> vector 0xCF then 0xD7 with o_int_req continuously high; o_miss_count=1 with macro, 0 without.
REQ-030 i_int_ack on the deadline cycle -> o_int_req stays 1, vector advances, o_miss_count unchanged.
REQ-031 i_reset low for 1 cycle while PENDING -> o_int_req=0 next cycle; the next request after 4 ticks carries 0xCF.
REQ-032 With macro, 300 unacknowledged deadlines -> o_miss_count saturates at 255 and holds.
